// File: rtl/upper_immediate_decoder_if.sv
// Handshake bundle between the upper-immediate decoder, its instruction source
// and the downstream ImmediateFormer. immediateFormerMode: 0 = LUI, 1 = AUIPC.
interface upper_immediate_decoder_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   flush;
    logic                   instValid;
    logic                   instReady;
    logic [31:0]            instruction;
    logic [31:0]            pcIn;
    logic                   outValid;
    logic                   outReady;
    logic                   immediateFormerMode;
    logic [31:0]            immediateU;
    logic [31:0]            pcOfInstruction;
    logic                   illegalInstruction;
    logic [COUNT_WIDTH-1:0] decodeCount;

    modport slave (
        input  flush, instValid, instruction, pcIn, outReady,
        output instReady, outValid, immediateFormerMode, immediateU,
               pcOfInstruction, illegalInstruction, decodeCount
    );

    modport master (
        output flush, instValid, instruction, pcIn, outReady,
        input  instReady, outValid, immediateFormerMode, immediateU,
               pcOfInstruction, illegalInstruction, decodeCount
    );
endinterface

// File: rtl/upper_immediate_decoder.sv
// Decodes LUI/AUIPC into {mode, U-immediate, pc} and queues them in a
// 2-entry in-order buffer toward the ImmediateFormer.
//
// state     | meaning
// OCC_EMPTY | no entries buffered, outValid low
// OCC_ONE   | head entry valid, one free slot
// OCC_TWO   | head and tail valid, instReady low
module upper_immediate_decoder #(
    parameter int COUNT_WIDTH = 16
) (
    input logic                     clock,
    input logic                     reset,
    upper_immediate_decoder_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic       MODE_LUI   = 1'b0;
    localparam logic       MODE_AUIPC = 1'b1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                   state_q, state_d;
    logic                   inst_ready, out_valid;
    logic                   in_hs, out_hs, is_lui, is_auipc, push, pop;
    logic                   load_head_new, load_tail_new, shift_tail;
    logic                   illegal_d, illegal_q, count_inc;
    logic                   head_mode_q, tail_mode_q, new_mode;
    logic [19:0]            head_imm_q, tail_imm_q;
    logic [31:0]            head_pc_q, tail_pc_q;
    logic [COUNT_WIDTH-1:0] count_q;

    // Ready and valid depend only on registered occupancy.
    assign inst_ready = (state_q != OCC_TWO);
    assign out_valid  = (state_q != OCC_EMPTY);

    assign is_lui    = (bus.instruction[6:0] == OPC_LUI);
    assign is_auipc  = (bus.instruction[6:0] == OPC_AUIPC);
    assign new_mode  = is_auipc ? MODE_AUIPC : MODE_LUI;
    assign in_hs     = bus.instValid & inst_ready;
    assign out_hs    = out_valid & bus.outReady;
    assign push      = in_hs & (is_lui | is_auipc);
    assign pop       = out_hs;
    assign illegal_d = in_hs & ~(is_lui | is_auipc) & ~bus.flush;
    assign count_inc = out_hs & ~bus.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_head_new = 1'b0;
        load_tail_new = 1'b0;
        shift_tail    = 1'b0;
        if (bus.flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        state_d       = OCC_ONE;
                        load_head_new = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        load_head_new = 1'b1;
                    end else if (push) begin
                        state_d       = OCC_TWO;
                        load_tail_new = 1'b1;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        state_d    = OCC_ONE;
                        shift_tail = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_mode_q <= MODE_LUI;
            head_imm_q  <= '0;
            head_pc_q   <= '0;
            tail_mode_q <= MODE_LUI;
            tail_imm_q  <= '0;
            tail_pc_q   <= '0;
        end else begin
            if (load_head_new) begin
                head_mode_q <= new_mode;
                head_imm_q  <= bus.instruction[31:12];
                head_pc_q   <= bus.pcIn;
            end else if (shift_tail) begin
                head_mode_q <= tail_mode_q;
                head_imm_q  <= tail_imm_q;
                head_pc_q   <= tail_pc_q;
            end
            if (load_tail_new) begin
                tail_mode_q <= new_mode;
                tail_imm_q  <= bus.instruction[31:12];
                tail_pc_q   <= bus.pcIn;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            illegal_q <= illegal_d;
            if (count_inc) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Head fields read as zero/LUI whenever the buffer is empty.
    assign bus.instReady           = inst_ready;
    assign bus.outValid            = out_valid;
    assign bus.immediateFormerMode = out_valid ? head_mode_q : MODE_LUI;
    assign bus.immediateU          = out_valid ? {head_imm_q, 12'h000} : 32'h0;
    assign bus.pcOfInstruction     = out_valid ? head_pc_q : 32'h0;
    assign bus.illegalInstruction  = illegal_q;
    assign bus.decodeCount         = count_q;
endmodule

// File: tb/tb_upper_immediate_decoder.sv
// Directed bench for upper_immediate_decoder: decode, buffering, flush,
// mid-stream reset and counter wrap on a narrow-counter instance.
module tb_upper_immediate_decoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] exp_count;

    upper_immediate_decoder_if #(.COUNT_WIDTH(16)) bif ();
    upper_immediate_decoder_if #(.COUNT_WIDTH(4))  bif4 ();

    upper_immediate_decoder #(.COUNT_WIDTH(16)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    upper_immediate_decoder #(.COUNT_WIDTH(4)) dut4 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        checks++; if (bif.outValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid: got %b expected 0", bif.outValid); end
        checks++; if (bif.decodeCount !== 16'h0) begin errors++; $display("FAIL rst_count: got %h expected 0000", bif.decodeCount); end
        checks++; if (bif.illegalInstruction !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b expected 0", bif.illegalInstruction); end
        checks++; if (bif.immediateU !== 32'h0 || bif.pcOfInstruction !== 32'h0 || bif.immediateFormerMode !== 1'b0)
            begin errors++; $display("FAIL rst_head: got imm %h pc %h mode %b expected 0 0 0", bif.immediateU, bif.pcOfInstruction, bif.immediateFormerMode); end
        checks++; if (bif4.decodeCount !== 4'h0) begin errors++; $display("FAIL rst_count4: got %h expected 0", bif4.decodeCount); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bif.instReady !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bif.instReady); end
        exp_count = 16'h0;
    endtask

    task automatic test_lui();
        bif.instValid   = 1'b1;
        bif.instruction = 32'h12345037;
        bif.pcIn        = 32'h100;
        bif.outReady    = 1'b1;
        tick();
        bif.instValid = 1'b0;
        checks++; if (bif.outValid !== 1'b1) begin errors++; $display("FAIL lui_valid: got %b expected 1", bif.outValid); end
        checks++; if (bif.immediateFormerMode !== 1'b0) begin errors++; $display("FAIL lui_mode: got %b expected 0", bif.immediateFormerMode); end
        checks++; if (bif.immediateU !== 32'h12345000) begin errors++; $display("FAIL lui_imm: got %h expected 12345000", bif.immediateU); end
        checks++; if (bif.pcOfInstruction !== 32'h100) begin errors++; $display("FAIL lui_pc: got %h expected 00000100", bif.pcOfInstruction); end
        tick();
        exp_count = exp_count + 16'd1;
        checks++; if (bif.decodeCount !== exp_count) begin errors++; $display("FAIL lui_count: got %h expected %h", bif.decodeCount, exp_count); end
        checks++; if (bif.outValid !== 1'b0) begin errors++; $display("FAIL lui_drain: got %b expected 0", bif.outValid); end
    endtask

    task automatic test_auipc();
        bif.instValid   = 1'b1;
        bif.instruction = 32'hFFFFF097;
        bif.pcIn        = 32'h200;
        bif.outReady    = 1'b1;
        tick();
        bif.instValid = 1'b0;
        checks++; if (bif.immediateFormerMode !== 1'b1) begin errors++; $display("FAIL auipc_mode: got %b expected 1", bif.immediateFormerMode); end
        checks++; if (bif.immediateU !== 32'hFFFFF000) begin errors++; $display("FAIL auipc_imm: got %h expected fffff000", bif.immediateU); end
        checks++; if (bif.pcOfInstruction !== 32'h200) begin errors++; $display("FAIL auipc_pc: got %h expected 00000200", bif.pcOfInstruction); end
        tick();
        exp_count = exp_count + 16'd1;
        checks++; if (bif.decodeCount !== exp_count) begin errors++; $display("FAIL auipc_count: got %h expected %h", bif.decodeCount, exp_count); end
    endtask

    task automatic test_illegal();
        bif.instValid   = 1'b1;
        bif.instruction = 32'h00000013;
        bif.pcIn        = 32'h300;
        bif.outReady    = 1'b1;
        tick();
        bif.instValid = 1'b0;
        checks++; if (bif.illegalInstruction !== 1'b1) begin errors++; $display("FAIL ill_pulse: got %b expected 1", bif.illegalInstruction); end
        checks++; if (bif.outValid !== 1'b0) begin errors++; $display("FAIL ill_valid: got %b expected 0", bif.outValid); end
        tick();
        checks++; if (bif.illegalInstruction !== 1'b0) begin errors++; $display("FAIL ill_width: got %b expected 0", bif.illegalInstruction); end
        checks++; if (bif.decodeCount !== exp_count) begin errors++; $display("FAIL ill_count: got %h expected %h", bif.decodeCount, exp_count); end
    endtask

    task automatic test_back_to_back();
        bif.outReady    = 1'b0;
        bif.instValid   = 1'b1;
        bif.instruction = 32'h11111037;
        bif.pcIn        = 32'h10;
        tick();
        checks++; if (bif.instReady !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", bif.instReady); end
        bif.instruction = 32'h22222037;
        bif.pcIn        = 32'h14;
        tick();
        checks++; if (bif.instReady !== 1'b0) begin errors++; $display("FAIL b2b_ready2: got %b expected 0", bif.instReady); end
        bif.instruction = 32'h33333037;
        bif.pcIn        = 32'h18;
        tick();
        checks++; if (bif.instReady !== 1'b0 || bif.immediateU !== 32'h11111000 || bif.pcOfInstruction !== 32'h10)
            begin errors++; $display("FAIL b2b_hold: got ready %b imm %h pc %h expected 0 11111000 00000010", bif.instReady, bif.immediateU, bif.pcOfInstruction); end
        bif.outReady = 1'b1;
        tick();
        checks++; if (bif.immediateU !== 32'h22222000 || bif.pcOfInstruction !== 32'h14)
            begin errors++; $display("FAIL b2b_second: got imm %h pc %h expected 22222000 00000014", bif.immediateU, bif.pcOfInstruction); end
        tick();
        bif.instValid = 1'b0;
        checks++; if (bif.outValid !== 1'b1 || bif.immediateU !== 32'h33333000 || bif.pcOfInstruction !== 32'h18)
            begin errors++; $display("FAIL b2b_third: got valid %b imm %h pc %h expected 1 33333000 00000018", bif.outValid, bif.immediateU, bif.pcOfInstruction); end
        tick();
        exp_count = exp_count + 16'd3;
        checks++; if (bif.decodeCount !== exp_count) begin errors++; $display("FAIL b2b_count: got %h expected %h", bif.decodeCount, exp_count); end
        checks++; if (bif.outValid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bif.outValid); end
    endtask

    task automatic test_flush();
        bif.outReady    = 1'b0;
        bif.instValid   = 1'b1;
        bif.instruction = 32'h44444037;
        bif.pcIn        = 32'h40;
        tick();
        bif.instruction = 32'h55555097;
        bif.pcIn        = 32'h44;
        tick();
        bif.instValid = 1'b0;
        bif.flush     = 1'b1;
        bif.outReady  = 1'b1;
        tick();
        bif.flush    = 1'b0;
        bif.outReady = 1'b0;
        checks++; if (bif.outValid !== 1'b0 || bif.instReady !== 1'b1 || bif.immediateU !== 32'h0)
            begin errors++; $display("FAIL flush_empty: got valid %b ready %b imm %h expected 0 1 0", bif.outValid, bif.instReady, bif.immediateU); end
        checks++; if (bif.decodeCount !== exp_count) begin errors++; $display("FAIL flush_count: got %h expected %h", bif.decodeCount, exp_count); end
        bif.flush       = 1'b1;
        bif.instValid   = 1'b1;
        bif.instruction = 32'h00000013;
        tick();
        bif.flush     = 1'b0;
        bif.instValid = 1'b0;
        checks++; if (bif.illegalInstruction !== 1'b0 || bif.outValid !== 1'b0)
            begin errors++; $display("FAIL flush_illegal: got ill %b valid %b expected 0 0", bif.illegalInstruction, bif.outValid); end
        bif.instValid   = 1'b1;
        bif.instruction = 32'h66666037;
        bif.pcIn        = 32'h48;
        bif.flush       = 1'b1;
        tick();
        bif.instValid = 1'b0;
        bif.flush     = 1'b0;
        checks++; if (bif.outValid !== 1'b0) begin errors++; $display("FAIL flush_push: got %b expected 0", bif.outValid); end
    endtask

    task automatic test_reset_mid();
        bif.outReady    = 1'b0;
        bif.instValid   = 1'b1;
        bif.instruction = 32'h77777037;
        bif.pcIn        = 32'h50;
        tick();
        bif.instruction = 32'h88888097;
        bif.pcIn        = 32'h54;
        tick();
        bif.instValid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bif.outValid !== 1'b0 || bif.immediateU !== 32'h0 || bif.pcOfInstruction !== 32'h0 || bif.immediateFormerMode !== 1'b0)
            begin errors++; $display("FAIL rmid_head: got valid %b imm %h pc %h mode %b expected all 0", bif.outValid, bif.immediateU, bif.pcOfInstruction, bif.immediateFormerMode); end
        checks++; if (bif.decodeCount !== 16'h0) begin errors++; $display("FAIL rmid_count: got %h expected 0000", bif.decodeCount); end
        #2 rst_n = 1'b1;
        exp_count = 16'h0;
        tick();
        checks++; if (bif.instReady !== 1'b1 || bif.outValid !== 1'b0)
            begin errors++; $display("FAIL rmid_after: got ready %b valid %b expected 1 0", bif.instReady, bif.outValid); end
    endtask

    task automatic test_wrap();
        bif4.instruction = 32'h0000A037;
        bif4.pcIn        = 32'h60;
        for (int i = 0; i < 17; i++) begin
            bif4.instValid = 1'b1;
            bif4.outReady  = 1'b0;
            tick();
            bif4.instValid = 1'b0;
            bif4.outReady  = 1'b1;
            tick();
            bif4.outReady = 1'b0;
            if (i == 15) begin
                checks++; if (bif4.decodeCount !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", bif4.decodeCount); end
            end
        end
        checks++; if (bif4.decodeCount !== 4'h1) begin errors++; $display("FAIL wrap_one: got %h expected 1", bif4.decodeCount); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 16'h0;
        rst_n     = 1'b1;
        bif.flush = 1'b0;   bif.instValid = 1'b0;  bif.outReady = 1'b0;
        bif.instruction = 32'h0;  bif.pcIn = 32'h0;
        bif4.flush = 1'b0;  bif4.instValid = 1'b0; bif4.outReady = 1'b0;
        bif4.instruction = 32'h0; bif4.pcIn = 32'h0;
        test_reset();
        test_lui();
        test_auipc();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/upper_immediate_decoder.md
UPPER_IMMEDIATE_DECODER -- requirements
Module: upper_immediate_decoder

Interface
REQ-001 SHALL have parameter: COUNT_WIDTH, 16, width of decodeCount.
REQ-002 SHALL have port: clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: flush  in  1  synchronous buffer clear.
REQ-005 SHALL have port: instValid  in  1  upstream instruction/PC pair valid.
REQ-006 SHALL have port: instReady  out  1  block can accept a pair this cycle.
REQ-007 SHALL have port: instruction  in  32  RV32I instruction word.
REQ-008 SHALL have port: pcIn  in  32  PC of instruction.
REQ-009 SHALL have port: outValid  out  1  head entry valid toward ImmediateFormer.
REQ-010 SHALL have port: outReady  in  1  downstream consumes head this cycle.
REQ-011 SHALL have port: immediateFormerMode  out  ImmediateFormerMode_t  LUI or AUIPC for head entry.
REQ-012 SHALL have port: immediateU  out  32  U-immediate of head entry.
REQ-013 SHALL have port: pcOfInstruction  out  32  PC of head entry.
REQ-014 SHALL have port: illegalInstruction  out  1  one-cycle pulse, rejected opcode.
REQ-015 SHALL have port: decodeCount  out  COUNT_WIDTH  count of completed output handshakes.

Function
REQ-016 SHALL hold a 2-entry in-order buffer of {mode, immediateU, pc}.
REQ-017 SHALL drive instReady = 1 iff buffer occupancy < 2, with no combinational path from outReady or instValid.
REQ-018 SHALL treat instValid & instReady as input handshake; outValid & outReady as output handshake.
REQ-019 SHALL decode instruction[6:0]: 7'b0110111 -> LUI, 7'b0010111 -> AUIPC.
REQ-020 SHALL form immediateU = {instruction[31:12], 12'b0}; no sign or PC arithmetic in this block.
REQ-021 SHALL consume (not enqueue) any handshaked instruction with other opcode, and pulse illegalInstruction high for exactly the cycle after acceptance.
REQ-022 SHALL drive outValid = 1 iff occupancy > 0; latency from input handshake to outValid = 1 cycle minimum.
REQ-023 SHALL, when outValid = 0, drive immediateFormerMode = LUI, immediateU = 0, pcOfInstruction = 0.
REQ-024 SHALL hold head outputs stable while outValid = 1 and outReady = 0.
REQ-025 SHALL, on simultaneous input and output handshake at occupancy 1, keep occupancy 1 with new entry as head next cycle.
REQ-026 SHALL increment decodeCount by 1 per output handshake, wrapping from all-ones to 0.
REQ-027 SHALL, on flush = 1, empty buffer next cycle, ignoring same-cycle input/output handshakes; decodeCount not incremented by that cycle's output handshake; illegalInstruction suppressed.
REQ-028 SHALL NOT alter decodeCount on flush.

Reset
REQ-029 SHALL, while reset = 0 (asynchronously), clear occupancy to 0, decodeCount to 0, illegalInstruction to 0, outValid to 0, head outputs per REQ-023.
REQ-030 SHALL drive instReady = 1 in the first cycle after reset deasserts.
REQ-031 SHALL discard buffered entries when reset asserts mid-operation; no entry survives reset.

Verification
REQ-032 SHALL cover: instruction 32'h12345037, pcIn 32'h100, outReady=1 -> next cycle outValid=1, mode LUI, immediateU 32'h12345000, pc 32'h100; decodeCount 1 after.
REQ-033 SHALL cover: instruction 32'hFFFFF097, pcIn 32'h200 -> mode AUIPC, immediateU 32'hFFFFF000, pc 32'h200.
REQ-034 SHALL cover: instruction 32'h00000013 handshaked -> illegalInstruction high one cycle, outValid stays 0, decodeCount unchanged.
REQ-035 SHALL cover: outReady=0, three back-to-back LUIs -> instReady 0 after two accepted; third held; release outReady -> order preserved, decodeCount 3.
REQ-036 SHALL cover: two entries buffered, flush=1 with outReady=1 -> occupancy 0 next cycle, decodeCount unchanged; reset=0 mid-stream -> all outputs zero immediately, instReady 1 after release.
REQ-037 SHALL cover: COUNT_WIDTH=4, 17 output handshakes -> decodeCount wraps to 1.
